regfile_mp_sb: RTL and testbench
================================

// Module: regfile_mp_sb
// PURPOSE
// Multi-port register file with an integrated writeback scoreboard, for the pipelined core datapath.
// Generalises the single-write register file: parametrised width/depth, N read and M write ports,
// optional hard-wired zero register, same-cycle write-to-read bypass, and per-register pending bits.
// The pending bits let decode stall on RAW hazards. Sits between decode (read/issue) and writeback (write).
// PARAMETERS
// XLEN      32  data width in bits
// NREGS     32  number of architectural registers (power of 2); AW = $clog2(NREGS)
// NRD       2   number of read ports
// NWR       2   number of write ports; a higher port index has higher priority
// ZERO_REG  1   1: register 0 always reads 0, ignores writes and is never pending
// BYPASS    1   1: a same-cycle write is forwarded to matching read ports
// PORTS
// clk         in   1         clock; all state updates on the rising edge
// rst         in   1         synchronous reset, active-high
// rd_addr     in   NRD*AW    read addresses; port i uses bits [i*AW +: AW]
// rd_data     out  NRD*XLEN  read data; port i uses bits [i*XLEN +: XLEN]
// rd_busy     out  NRD       1 = port i's register is pending and its value is not bypassed this cycle
// wr_en       in   NWR       per-port write enable
// wr_addr     in   NWR*AW    write addresses
// wr_data     in   NWR*XLEN  write data
// issue_en    in   1         marks issue_addr as pending (a producer has been issued)
// issue_addr  in   AW        destination register of the issued instruction
// debug_addr  in   AW        debug read address
// debug_data  out  XLEN      debug read data; raw array contents, no bypass
// BEHAVIOUR
// - Reset: while rst=1 at a rising edge, all registers <= 0 and all pending bits <= 0. Reset overrides
//   any write or issue in the same cycle. Outputs are combinational from state, so rd_data, debug_data
//   and rd_busy read 0 from the first cycle after reset (given no bypass hits).
// - Write: on the rising edge, each port with wr_en=1 writes wr_data to wr_addr. When ZERO_REG=1, writes
//   to address 0 are dropped. If several ports write the same address, the highest-index port wins.
// - Read: combinational. When ZERO_REG=1, address 0 returns 0. When BYPASS=1 and any enabled write port
//   targets rd_addr (non-zero, or any address when ZERO_REG=0), rd_data returns the winning port's
//   wr_data; otherwise it returns the stored value. Latency: 0 with bypass, 1 cycle without.
// - Scoreboard: pending[r] is set when issue_en=1 and issue_addr=r, and cleared when any enabled write
//   targets r. If issue and write hit the same r in one cycle, issue wins and pending stays 1, because
//   the new producer is outstanding. Register 0 is never pending when ZERO_REG=1.
// - rd_busy[i] = pending[rd_addr_i] & ~(BYPASS & bypass hit on port i). It reflects the current pending
//   state only; an issue in the same cycle does not affect rd_busy until the next cycle.
// - Writes to non-pending registers are legal and do not change pending state.
// - Out-of-range addresses cannot occur, since NREGS = 2^AW.
// STRUCTURE
// - Shared package regfile_pkg: default XLEN/NREGS/NRD/NWR localparams, the AW function ($clog2),
//   and the register-address typedef reg_addr_t.
// - Sub-module regfile_scoreboard: the pending bit vector plus the set/clear priority logic, with
//   busy lookup for NRD ports. The top level holds the storage array, write-priority mux and bypass muxes.
// TESTING
// 1. Reset with rst=1 for 1 cycle after random writes -> every register reads 0 and rd_busy=0.
// 2. wr port0 (r5,0xAAAA) and port1 (r5,0x5555) in the same cycle -> r5 = 0x5555 next cycle;
//    rd_addr=r5 in that same cycle with BYPASS=1 reads 0x5555.
// 3. ZERO_REG=1: write r0=0xDEADBEEF and issue r0 -> r0 reads 0 and rd_busy stays 0.
// 4. Issue r7 -> rd_busy=1 next cycle. Write r7=0x1234 -> rd_busy=0 in the write cycle (bypass) and
//    stays 0 after, with r7=0x1234.
// 5. Issue r9 and write r9=0x42 in the same cycle -> r9=0x42 and pending[r9] stays 1; cleared only by
//    the next write to r9.
// 6. rst asserted in the same cycle as write r3=0x77 and issue r3 -> r3=0, not pending; debug_data(r3)=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default sizes,
// address-width helper and the architectural register address type.
package regfile_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int NRD_DEF   = 2;
   localparam int NWR_DEF   = 2;

   function automatic int calc_aw(input int nregs);
      return (nregs <= 1) ? 1 : $clog2(nregs);
   endfunction

   localparam int AW_DEF = calc_aw(NREGS_DEF);

   typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set on issue, cleared by
// writeback, with per-read-port busy lookup.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS    = NREGS_DEF,
   parameter int NRD      = NRD_DEF,
   parameter int NWR      = NWR_DEF,
   parameter int ZERO_REG = 1,
   parameter int AW       = calc_aw(NREGS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_en,
   input  logic [AW-1:0]     issue_addr,
   input  logic [NWR-1:0]    wr_en,
   input  logic [NWR*AW-1:0] wr_addr,
   input  logic [NRD*AW-1:0] rd_addr,
   input  logic [NRD-1:0]    rd_fwd,
   output logic [NRD-1:0]    rd_busy
);

   logic [NREGS-1:0] pending_q;
   logic [NREGS-1:0] pending_d;

   // Issue is applied after the clears: a fresh producer stays outstanding.
   always_comb begin
      pending_d = pending_q;
      for (int j = 0; j < NWR; j++) begin
         if (wr_en[j]) pending_d[wr_addr[j*AW +: AW]] = 1'b0;
      end
      if (issue_en) pending_d[issue_addr] = 1'b1;
      if (ZERO_REG != 0) pending_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) pending_q <= '0;
      else     pending_q <= pending_d;
   end

   always_comb begin
      rd_busy = '0;
      for (int i = 0; i < NRD; i++) begin
         rd_busy[i] = pending_q[rd_addr[i*AW +: AW]] & ~rd_fwd[i];
      end
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-to-read bypass and an attached
// writeback scoreboard for RAW stall detection in decode.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int NRD      = NRD_DEF,
   parameter int NWR      = NWR_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1,
   parameter int AW       = calc_aw(NREGS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NRD*AW-1:0]   rd_addr,
   output logic [NRD*XLEN-1:0] rd_data,
   output logic [NRD-1:0]      rd_busy,
   input  logic [NWR-1:0]      wr_en,
   input  logic [NWR*AW-1:0]   wr_addr,
   input  logic [NWR*XLEN-1:0] wr_data,
   input  logic                issue_en,
   input  logic [AW-1:0]       issue_addr,
   input  logic [AW-1:0]       debug_addr,
   output logic [XLEN-1:0]     debug_data
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic [NRD-1:0]  rd_hit;
   logic [XLEN-1:0] rd_fwd_data [NRD];

   // Ascending port order lets the highest-index writer win on collisions.
   always_comb begin
      regs_d = regs_q;
      for (int j = 0; j < NWR; j++) begin
         if (wr_en[j] && !((ZERO_REG != 0) && (wr_addr[j*AW +: AW] == '0))) begin
            regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) regs_q <= '{default: '0};
      else     regs_q <= regs_d;
   end

   always_comb begin
      rd_data = '0;
      rd_hit  = '0;
      for (int i = 0; i < NRD; i++) begin
         rd_fwd_data[i] = regs_q[rd_addr[i*AW +: AW]];
         for (int j = 0; j < NWR; j++) begin
            if ((BYPASS != 0) && wr_en[j] && (wr_addr[j*AW +: AW] == rd_addr[i*AW +: AW])) begin
               rd_hit[i]      = 1'b1;
               rd_fwd_data[i] = wr_data[j*XLEN +: XLEN];
            end
         end
         if ((ZERO_REG != 0) && (rd_addr[i*AW +: AW] == '0)) begin
            rd_hit[i] = 1'b0;
         end else begin
            rd_data[i*XLEN +: XLEN] = rd_fwd_data[i];
         end
      end
   end

   assign debug_data = regs_q[debug_addr];

   regfile_scoreboard #(
      .NREGS   (NREGS),
      .NRD     (NRD),
      .NWR     (NWR),
      .ZERO_REG(ZERO_REG),
      .AW      (AW)
   ) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .issue_en  (issue_en),
      .issue_addr(issue_addr),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .rd_addr   (rd_addr),
      .rd_fwd    (rd_hit),
      .rd_busy   (rd_busy)
   );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: directed hazard/priority cases
// followed by randomised traffic checked against a reference model.
module tb_regfile_mp_sb;
   import regfile_pkg::*;

   localparam int XLEN = 32;
   localparam int AW   = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [2*AW-1:0] rd_addr;
   logic [63:0]     rd_data;
   logic [1:0]      rd_busy;
   logic [1:0]      wr_en;
   logic [2*AW-1:0] wr_addr;
   logic [63:0]     wr_data;
   logic            issue_en;
   reg_addr_t       issue_addr;
   reg_addr_t       debug_addr;
   logic [31:0]     debug_data;

   logic [31:0] mdl [32];
   logic        mdl_pend [32];
   logic [31:0] exp_q [$];
   int          n_total = 0;
   int          n_bad   = 0;

   regfile_mp_sb #(
      .XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .ZERO_REG(1), .BYPASS(1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_busy   (rd_busy),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .issue_en  (issue_en),
      .issue_addr(issue_addr),
      .debug_addr(debug_addr),
      .debug_data(debug_data)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic wr(input int port, input int addr, input logic [31:0] d);
      wr_en[port]             = 1'b1;
      wr_addr[port*AW +: AW]  = addr[AW-1:0];
      wr_data[port*XLEN +: XLEN] = d;
   endtask

   task automatic issue(input int addr);
      issue_en   = 1'b1;
      issue_addr = addr[AW-1:0];
   endtask

   // Advance the reference model with the inputs currently driven, then clock.
   task automatic tick();
      int a;
      if (rst) begin
         for (int r = 0; r < 32; r++) begin
            mdl[r]      = '0;
            mdl_pend[r] = 1'b0;
         end
      end else begin
         for (int j = 0; j < 2; j++) begin
            if (wr_en[j]) begin
               a = int'(wr_addr[j*AW +: AW]);
               if (a != 0) mdl[a] = wr_data[j*XLEN +: XLEN];
               mdl_pend[a] = 1'b0;
            end
         end
         if (issue_en && issue_addr != 0) mdl_pend[int'(issue_addr)] = 1'b1;
      end
      @(posedge clk);
      #1;
      rst      = 1'b0;
      wr_en    = '0;
      issue_en = 1'b0;
   endtask

   function automatic logic [31:0] exp_data(input int a);
      logic [31:0] v;
      v = mdl[a];
      if (a == 0) return '0;
      for (int j = 0; j < 2; j++) begin
         if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) v = wr_data[j*XLEN +: XLEN];
      end
      return v;
   endfunction

   function automatic logic exp_busy(input int a);
      logic hit;
      hit = 1'b0;
      if (a == 0) return 1'b0;
      for (int j = 0; j < 2; j++) begin
         if (wr_en[j] && int'(wr_addr[j*AW +: AW]) == a) hit = 1'b1;
      end
      return mdl_pend[a] & ~hit;
   endfunction

   task automatic set_rd(input int a0, input logic [31:0] d0, input logic b0,
                         input int a1, input logic [31:0] d1, input logic b1);
      rd_addr = {a1[AW-1:0], a0[AW-1:0]};
      exp_q.push_back(d0);
      exp_q.push_back({31'b0, b0});
      exp_q.push_back(d1);
      exp_q.push_back({31'b0, b1});
   endtask

   task automatic set_rd_model(input int a0, input int a1);
      set_rd(a0, exp_data(a0), exp_busy(a0), a1, exp_data(a1), exp_busy(a1));
   endtask

   task automatic cmp_rd(input string tag);
      logic [31:0] e;
      #1;
      for (int p = 0; p < 2; p++) begin
         e = exp_q.pop_front();
         check_val($sformatf("%s_data%0d", tag, p), rd_data[p*XLEN +: XLEN], e);
         e = exp_q.pop_front();
         check_val($sformatf("%s_busy%0d", tag, p), {31'b0, rd_busy[p]}, e);
      end
   endtask

   task automatic dbg_chk(input int a, input logic [31:0] e, input string tag);
      debug_addr = a[AW-1:0];
      #1;
      check_val(tag, debug_data, e);
   endtask

   initial begin
      rst = 1'b1; rd_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0;
      issue_en = 1'b0; issue_addr = '0; debug_addr = '0;
      for (int r = 0; r < 32; r++) begin
         mdl[r] = '0;
         mdl_pend[r] = 1'b0;
      end
      tick();

      // Random writes and issues, then a single reset cycle clears everything.
      for (int c = 0; c < 20; c++) begin
         wr(0, $urandom_range(1, 31), $urandom);
         wr(1, $urandom_range(1, 31), $urandom);
         issue($urandom_range(1, 31));
         tick();
      end
      rst = 1'b1;
      tick();
      for (int r = 0; r < 32; r += 2) begin
         set_rd(r, 32'h0, 1'b0, r + 1, 32'h0, 1'b0);
         cmp_rd("rst_rd");
         dbg_chk(r, 32'h0, "rst_dbg");
         tick();
      end

      // Same-address collision: highest port wins, also on the bypass path.
      wr(0, 5, 32'h0000AAAA);
      wr(1, 5, 32'h00005555);
      set_rd(5, 32'h00005555, 1'b0, 0, 32'h0, 1'b0);
      cmp_rd("prio_byp");
      tick();
      set_rd(5, 32'h00005555, 1'b0, 6, 32'h0, 1'b0);
      cmp_rd("prio_held");
      dbg_chk(5, 32'h00005555, "prio_dbg");

      // Register zero ignores writes and never becomes pending.
      wr(0, 0, 32'hDEADBEEF);
      issue(0);
      set_rd(0, 32'h0, 1'b0, 5, 32'h00005555, 1'b0);
      cmp_rd("zero_same");
      tick();
      set_rd(0, 32'h0, 1'b0, 0, 32'h0, 1'b0);
      cmp_rd("zero_next");
      dbg_chk(0, 32'h0, "zero_dbg");

      // Issue then writeback: busy until the write, bypassed in the write cycle.
      issue(7);
      set_rd(7, 32'h0, 1'b0, 5, 32'h00005555, 1'b0);
      cmp_rd("iss_same");
      tick();
      set_rd(7, 32'h0, 1'b1, 5, 32'h00005555, 1'b0);
      cmp_rd("iss_busy");
      wr(1, 7, 32'h00001234);
      set_rd(7, 32'h00001234, 1'b0, 7, 32'h00001234, 1'b0);
      cmp_rd("wb_byp");
      tick();
      set_rd(7, 32'h00001234, 1'b0, 5, 32'h00005555, 1'b0);
      cmp_rd("wb_after");
      dbg_chk(7, 32'h00001234, "wb_dbg");

      // Issue and write of the same register in one cycle: pending survives.
      issue(9);
      wr(0, 9, 32'h00000042);
      tick();
      set_rd(9, 32'h00000042, 1'b1, 7, 32'h00001234, 1'b0);
      cmp_rd("iw_pend");
      dbg_chk(9, 32'h00000042, "iw_dbg");
      tick();
      set_rd(9, 32'h00000042, 1'b1, 0, 32'h0, 1'b0);
      cmp_rd("iw_still");
      wr(0, 9, 32'h00000043);
      set_rd(9, 32'h00000043, 1'b0, 0, 32'h0, 1'b0);
      cmp_rd("iw_clr_byp");
      tick();
      set_rd(9, 32'h00000043, 1'b0, 0, 32'h0, 1'b0);
      cmp_rd("iw_clr");

      // Reset overrides a simultaneous write and issue.
      wr(0, 3, 32'h00000011);
      tick();
      rst = 1'b1;
      wr(0, 3, 32'h00000077);
      issue(3);
      tick();
      set_rd(3, 32'h0, 1'b0, 9, 32'h0, 1'b0);
      cmp_rd("rst_ovr");
      dbg_chk(3, 32'h0, "rst_ovr_dbg");
      tick();

      // Random traffic against the reference model.
      for (int c = 0; c < 400; c++) begin
         int da;
         if ($urandom_range(0, 2) != 0) wr(0, $urandom_range(0, 7), $urandom);
         if ($urandom_range(0, 2) != 0) wr(1, $urandom_range(0, 7), $urandom);
         if ($urandom_range(0, 1) != 0) issue($urandom_range(0, 7));
         set_rd_model($urandom_range(0, 7), $urandom_range(0, 7));
         cmp_rd("rand");
         da = $urandom_range(0, 7);
         dbg_chk(da, mdl[da], "rand_dbg");
         tick();
      end

      if (exp_q.size() != 0) check_val("queue_left", exp_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
